// File: rtl/edge_detect_pkg.sv
// Shared constants for the multi-channel edge detector with veto windows.
// Parameter defaults and synchronizer depth live here so every file agrees.
package edge_detect_pkg;

  localparam int unsigned NCH_DEF    = 4;
  localparam int unsigned NPH_DEF    = 2;
  localparam int unsigned VW_DEF     = 3;
  localparam int unsigned CW_DEF     = 16;
  localparam int unsigned SYNC_DEPTH = 3;

endpackage

// File: rtl/toggle_sync_edge.sv
// Three-flop synchronizer for one asynchronous toggle line.
// Emits a registered one-cycle pulse whenever the synchronized level changes.
module toggle_sync_edge
  import edge_detect_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tog,
  output logic hitEdge
);

  logic [SYNC_DEPTH-1:0] syncQ;

  // The edge (stage2 XOR stage3) is registered here so the top-level
  // veto/detect stage sees a clean flop output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncQ   <= '0;
      hitEdge <= 1'b0;
    end else begin
      syncQ   <= {syncQ[SYNC_DEPTH-2:0], tog};
      hitEdge <= syncQ[SYNC_DEPTH-2] ^ syncQ[SYNC_DEPTH-1];
    end
  end

endmodule

// File: rtl/edge_detect_multi_veto.sv
// Multi-channel photon edge detector with per-channel or global veto windows.
// Delivers one-cycle det pulses and keeps saturating delivered/vetoed counters.
module edge_detect_multi_veto
  import edge_detect_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned NPH = NPH_DEF,
  parameter int unsigned VW  = VW_DEF,
  parameter int unsigned CW  = CW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH*NPH-1:0]  tog_hit,
  input  logic [NCH-1:0]      tog_any,
  input  logic [VW-1:0]       veto_len,
  input  logic                veto_retrig,
  input  logic                veto_global,
  input  logic                cnt_clr,
  output logic [NCH*NPH-1:0]  det,
  output logic [NCH*CW-1:0]   det_cnt,
  output logic [NCH*CW-1:0]   veto_cnt
);

  localparam int unsigned NB  = NCH * NPH;
  localparam int unsigned PW  = $clog2(NPH + 1);
  localparam int unsigned PCW = $clog2(SYNC_DEPTH + 1);
  localparam logic [PCW-1:0] PRIME_END = PCW'(SYNC_DEPTH);
  localparam logic [CW-1:0]  CNT_MAX   = '1;

  logic [NB-1:0]  hitEdge;
  logic [NCH-1:0] anyEdge;
  logic [NCH-1:0] active;
  logic           anyActive;
  logic [PCW-1:0] primeCnt;
  logic           primed;

  for (genvar b = 0; b < NB; b++) begin : gHitSync
    toggle_sync_edge uSync (
      .clk     (clk),
      .reset   (reset),
      .tog     (tog_hit[b]),
      .hitEdge (hitEdge[b])
    );
  end

  for (genvar c = 0; c < NCH; c++) begin : gAnySync
    toggle_sync_edge uSync (
      .clk     (clk),
      .reset   (reset),
      .tog     (tog_any[c]),
      .hitEdge (anyEdge[c])
    );
  end

  // Output and counting stay masked until the sync chains hold post-reset data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primeCnt <= '0;
    end else if (primeCnt != PRIME_END) begin
      primeCnt <= primeCnt + 1'b1;
    end
  end

  assign primed    = (primeCnt == PRIME_END);
  assign anyActive = |active;

  for (genvar c = 0; c < NCH; c++) begin : gCh
    logic [VW-1:0]  vcnt;
    logic [NPH-1:0] chHit;
    logic [NPH-1:0] chDet;
    logic [NPH-1:0] chVeto;
    logic [NPH-1:0] detQ;
    logic [PW-1:0]  nDet;
    logic [PW-1:0]  nVeto;
    logic [CW:0]    detSum;
    logic [CW:0]    vetoSum;
    logic [CW-1:0]  detCntQ;
    logic [CW-1:0]  vetoCntQ;
    logic           ev;
    logic           blocked;

    assign chHit     = hitEdge[c*NPH +: NPH];
    assign ev        = anyEdge[c] | (|chHit);
    assign active[c] = (vcnt != '0);
    assign blocked   = veto_global ? anyActive : active[c];
    assign chDet     = (primed && !blocked) ? chHit : '0;
    assign chVeto    = (primed &&  blocked) ? chHit : '0;

    always_comb begin
      nDet  = '0;
      nVeto = '0;
      for (int unsigned p = 0; p < NPH; p++) begin
        nDet  = nDet  + PW'(chDet[p]);
        nVeto = nVeto + PW'(chVeto[p]);
      end
    end

    assign detSum  = {1'b0, detCntQ}  + (CW+1)'(nDet);
    assign vetoSum = {1'b0, vetoCntQ} + (CW+1)'(nVeto);

    // veto_len is captured only on load; later changes wait for the next window.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vcnt <= '0;
      end else if (ev && (!active[c] || veto_retrig)) begin
        vcnt <= veto_len;
      end else if (active[c]) begin
        vcnt <= vcnt - 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        detQ     <= '0;
        detCntQ  <= '0;
        vetoCntQ <= '0;
      end else begin
        detQ <= chDet;
        if (cnt_clr) begin
          detCntQ  <= '0;
          vetoCntQ <= '0;
        end else begin
          detCntQ  <= detSum[CW]  ? CNT_MAX : detSum[CW-1:0];
          vetoCntQ <= vetoSum[CW] ? CNT_MAX : vetoSum[CW-1:0];
        end
      end
    end

    assign det[c*NPH +: NPH]     = detQ;
    assign det_cnt[c*CW +: CW]   = detCntQ;
    assign veto_cnt[c*CW +: CW]  = vetoCntQ;
  end

endmodule

// File: tb/tb_edge_detect_multi_veto.sv
// Bench for edge_detect_multi_veto: directed scenarios plus randomized toggles,
// checked every cycle against a time-window reference model.
module tb_edge_detect_multi_veto;

  localparam int NCH  = 4;
  localparam int NPH  = 2;
  localparam int VW   = 3;
  localparam int CW   = 4;
  localparam int NB   = NCH * NPH;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NB-1:0]     tog_hit;
  logic [NCH-1:0]    tog_any;
  logic [VW-1:0]     veto_len;
  logic              veto_retrig;
  logic              veto_global;
  logic              cnt_clr;
  logic [NB-1:0]     det;
  logic [NCH*CW-1:0] det_cnt;
  logic [NCH*CW-1:0] veto_cnt;

  initial forever #5 clk = ~clk;

  edge_detect_multi_veto #(.NCH(NCH), .NPH(NPH), .VW(VW), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .tog_hit     (tog_hit),
    .tog_any     (tog_any),
    .veto_len    (veto_len),
    .veto_retrig (veto_retrig),
    .veto_global (veto_global),
    .cnt_clr     (cnt_clr),
    .det         (det),
    .det_cnt     (det_cnt),
    .veto_cnt    (veto_cnt)
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: input history sampled per edge, windows as absolute end times.
  logic [NB-1:0]  hh [5];
  logic [NCH-1:0] ha [5];
  logic [NB-1:0]  hitE;
  logic [NCH-1:0] anyE;
  logic [NCH-1:0] blk;
  logic [NB-1:0]  expDet;
  int             winEnd [NCH];
  int             expDc  [NCH];
  int             expVc  [NCH];
  int             nEdge;
  int             nd, nv;
  bit             anyWin, evc, modelOn = 1'b0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      nEdge  = 0;
      expDet = '0;
      for (int k = 0; k < 5; k++) begin hh[k] = '0; ha[k] = '0; end
      for (int c = 0; c < NCH; c++) begin winEnd[c] = -1; expDc[c] = 0; expVc[c] = 0; end
    end else begin
      nEdge++;
      for (int k = 4; k > 0; k--) begin hh[k] = hh[k-1]; ha[k] = ha[k-1]; end
      hh[0] = tog_hit;
      ha[0] = tog_any;
      // An input change first sampled at edge n reaches det at edge n+3.
      hitE = hh[3] ^ hh[4];
      anyE = ha[3] ^ ha[4];
      anyWin = 1'b0;
      for (int c = 0; c < NCH; c++) if (nEdge <= winEnd[c]) anyWin = 1'b1;
      for (int c = 0; c < NCH; c++) blk[c] = veto_global ? anyWin : (nEdge <= winEnd[c]);
      for (int c = 0; c < NCH; c++) begin
        nd = 0; nv = 0;
        evc = anyE[c];
        for (int p = 0; p < NPH; p++) begin
          expDet[c*NPH+p] = (nEdge > 3) && hitE[c*NPH+p] && !blk[c];
          if (hitE[c*NPH+p]) evc = 1'b1;
          if ((nEdge > 3) && hitE[c*NPH+p]) begin
            if (blk[c]) nv++; else nd++;
          end
        end
        if (cnt_clr) begin
          expDc[c] = 0; expVc[c] = 0;
        end else begin
          expDc[c] = (expDc[c] + nd > CMAX) ? CMAX : expDc[c] + nd;
          expVc[c] = (expVc[c] + nv > CMAX) ? CMAX : expVc[c] + nv;
        end
        if (evc && (nEdge > winEnd[c] || veto_retrig)) winEnd[c] = nEdge + int'(veto_len);
      end
    end
  end

  logic [NCH*CW-1:0] eD, eV;
  initial forever begin
    @(negedge clk);
    if (modelOn) begin
      for (int c = 0; c < NCH; c++) begin
        eD[c*CW +: CW] = CW'(expDc[c]);
        eV[c*CW +: CW] = CW'(expVc[c]);
      end
      chk("det", det, expDet);
      chk("det_cnt", det_cnt, eD);
      chk("veto_cnt", veto_cnt, eV);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clrCnt();
    @(negedge clk) cnt_clr = 1'b1;
    @(negedge clk) cnt_clr = 1'b0;
  endtask

  task automatic flip(input int b);
    @(negedge clk) tog_hit[b] = ~tog_hit[b];
  endtask

  // Three events on bit b at cycles t, t+2, t+4.
  task automatic triple(input int b);
    flip(b); idle(1); flip(b); idle(1); flip(b);
  endtask

  initial begin
    tog_hit = '0; tog_any = '0; veto_len = '0;
    veto_retrig = 1'b0; veto_global = 1'b0; cnt_clr = 1'b0;
    #2 reset = 1'b1;
    idle(2);
    chk("rst_det", det, 0);
    chk("rst_dcnt", det_cnt, 0);
    chk("rst_vcnt", veto_cnt, 0);
    modelOn = 1'b1;
    reset = 1'b0;
    idle(8);

    // Single hit, no veto: pulse after the 4th edge, one cycle wide.
    clrCnt();
    flip(0);
    idle(3); chk("t1_early", det, 0);
    idle(1); chk("t1_det", det, 8'h01);
    idle(1); chk("t1_late", det, 0);
    chk("t1_cnt", det_cnt[CW-1:0], 1);

    // Non-retriggering window of 3.
    veto_len = 3; clrCnt(); idle(4);
    triple(0); idle(10);
    chk("t2_det", det_cnt[CW-1:0], 2);
    chk("t2_veto", veto_cnt[CW-1:0], 1);

    // Retriggering window of 3.
    veto_retrig = 1'b1; clrCnt(); idle(6);
    triple(0); idle(10);
    chk("t3_det", det_cnt[CW-1:0], 1);
    chk("t3_veto", veto_cnt[CW-1:0], 2);
    veto_retrig = 1'b0;

    // Global veto: ch0 window suppresses ch1 one cycle later.
    veto_global = 1'b1; clrCnt(); idle(6);
    flip(0); flip(2); idle(10);
    chk("t4g_det1", det_cnt[2*CW-1:CW], 0);
    chk("t4g_veto1", veto_cnt[2*CW-1:CW], 1);
    chk("t4g_det0", det_cnt[CW-1:0], 1);
    veto_global = 1'b0; clrCnt(); idle(6);
    flip(0); flip(2); idle(10);
    chk("t4l_det1", det_cnt[2*CW-1:CW], 1);
    chk("t4l_veto1", veto_cnt[2*CW-1:CW], 0);

    // Saturation at 15, then clear coinciding with a delivered pulse.
    veto_len = 0; clrCnt();
    for (int i = 0; i < 20; i++) begin flip(0); idle(1); end
    idle(6);
    chk("t5_sat", det_cnt[CW-1:0], 15);
    flip(0); idle(3); cnt_clr = 1'b1;
    idle(1); cnt_clr = 1'b0;
    chk("t5_clr_det", det[0], 1);
    chk("t5_clr_cnt", det_cnt[CW-1:0], 0);

    // Reset in the middle of a window with tog_hit[0] held high.
    @(negedge clk) begin tog_hit = '0; tog_any = '0; end
    veto_len = 7; idle(8);
    flip(0); idle(5);
    chk("t6_win", dut.gCh[0].vcnt, 6);
    reset = 1'b1;
    idle(1); chk("t6_rst_v", dut.gCh[0].vcnt, 0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      chk("t6_prime_det", det, 0);
      chk("t6_prime_v", dut.gCh[0].vcnt, 0);
    end
    idle(10);

    // Randomized toggles, settings and clears.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      tog_hit ^= NB'($urandom & $urandom & $urandom);
      tog_any ^= NCH'($urandom & $urandom & $urandom & $urandom);
      cnt_clr = ($urandom_range(0, 29) == 0);
      if (i % 150 == 0) begin
        veto_len    = VW'($urandom);
        veto_retrig = 1'($urandom);
        veto_global = 1'($urandom);
      end
      if (i % 37 == 5) veto_len = VW'($urandom);
      if (i == 2000) reset = 1'b1;
      if (i == 2002) reset = 1'b0;
    end
    cnt_clr = 1'b0;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi_veto.md
EDGE_DETECT_MULTI_VETO -- requirements
Module: edge_detect_multi_veto

Interface
REQ-001 SHALL have parameter NCH, default 4: number of photon channels.
REQ-002 SHALL have parameter NPH, default 2: valid phases per channel (phase 0 = A/rising, phase 1 = B/falling).
REQ-003 SHALL have parameter VW, default 3: veto-length width (max window 2^VW-1 cycles).
REQ-004 SHALL have parameter CW, default 16: counter width.
REQ-005 SHALL have ports: clk input 1 (sole clock); reset input 1 (asynchronous, active-high).
REQ-006 SHALL have port tog_hit input NCH*NPH: per-channel/phase toggle from capture stage, asynchronous to clk; index c*NPH+p.
REQ-007 SHALL have port tog_any input NCH: per-channel toggle flipping on every photon, valid or not, asynchronous to clk.
REQ-008 SHALL have port veto_len input VW: veto window in cycles; 0 disables veto.
REQ-009 SHALL have port veto_retrig input 1: 1 = window restarts on each event; 0 = non-extending.
REQ-010 SHALL have port veto_global input 1: 1 = any channel's window suppresses all channels.
REQ-011 SHALL have port cnt_clr input 1: synchronous clear of all counters.
REQ-012 SHALL have port det output NCH*NPH: one-cycle detection pulses, registered to clk.
REQ-013 SHALL have port det_cnt output NCH*CW: delivered pulses per channel, channel c at [c*CW +: CW].
REQ-014 SHALL have port veto_cnt output NCH*CW: suppressed phase hits per channel.

Function
REQ-015 SHALL pass each tog_hit/tog_any bit through a 3-flop chain; an edge SHALL be stage2 XOR stage3.
REQ-016 SHALL define ev[c] = tog_any edge OR any tog_hit edge of channel c in the same cycle.
REQ-017 SHALL keep per-channel down-counter vcnt[c] (VW bits): on ev[c], load veto_len if vcnt[c]==0 or veto_retrig=1; otherwise decrement if nonzero.
REQ-018 SHALL define blocked[c] = (vcnt[c]!=0), or OR over all vcnt when veto_global=1, evaluated on pre-update vcnt.
REQ-019 SHALL register det[c*NPH+p] = hit edge AND NOT blocked[c]; det high exactly one cycle, 4 clk edges after the first edge sampling the new toggle value.
REQ-020 SHALL, for veto_len=L and event at cycle t, suppress hits at t+1..t+L and deliver at t+L+1 (non-retrig, no intervening events).
REQ-021 SHALL deliver simultaneous hits on different channels or phases of the same cycle independently; the arming event itself is never suppressed.
REQ-022 SHALL sample veto_len only at load; mid-window changes affect the next window only.
REQ-023 SHALL increment det_cnt[c] by the number of det bits of channel c asserted (0..NPH) and veto_cnt[c] by suppressed hits, both saturating at 2^CW-1.
REQ-024 SHALL give cnt_clr priority over increments in the same cycle.
REQ-025 SHALL suppress det and counting for the first 3 cycles after reset release (sync-chain priming); veto counters still load.

Reset
REQ-026 SHALL on reset assertion clear immediately: all sync flops, vcnt, det, det_cnt, veto_cnt, startup counter.
REQ-027 SHALL tolerate reset mid-window: the window is abandoned and no pulse emitted until REQ-025 expires.

Structure
REQ-028 SHALL place parameter defaults and the sync depth constant (3) in shared package edge_detect_pkg.
REQ-029 SHALL instantiate sub-module toggle_sync_edge (3-flop sync + XOR edge, 1 bit) per tog_hit/tog_any bit.
REQ-030 SHALL keep veto logic and counters in the top module with generate loops over NCH/NPH.

Verification
REQ-031 SHALL check: single tog_hit[0] flip, veto_len=0 -> det[0] high one cycle, 4 edges later; det_cnt[0]=1.
REQ-032 SHALL check: veto_len=3, events ch0 at t, t+2, t+4 (non-retrig) -> delivered t and t+4; veto_cnt[0]=1.
REQ-033 SHALL check: veto_len=3, retrig=1, events at t, t+2, t+4 -> only t delivered; veto_cnt[0]=2.
REQ-034 SHALL check: veto_global=1, ch0 event at t, ch1 hit at t+1 -> ch1 suppressed; veto_global=0 -> ch1 delivered.
REQ-035 SHALL check: CW=4, 20 spaced hits -> det_cnt=15; cnt_clr coincident with hit -> 0.
REQ-036 SHALL check: tog_hit held 1 through reset, reset released mid-window -> no det within 3 cycles, vcnt=0.
